// File: rtl/alu_iter.sv
// ============================================================================
// Module   : alu_iter
// Brief    : Multi-cycle ALU with single-cycle logic/arith ops and an
//            iterative shift-add multiplier. Define ALU_DIVU_EN to add the
//            iterative restoring divider for code 7.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] MuxAtoALU,
  input  logic [WIDTH-1:0] MuxBtoALU,
  input  logic [2:0]       ALUControl,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] HiOut,
  output logic             Zero
);

  localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ITER = 2'd1;
  localparam logic [1:0] c_FIN  = 2'd2;

  localparam logic [2:0] c_OP_ADD   = 3'd0;
  localparam logic [2:0] c_OP_SUB   = 3'd1;
  localparam logic [2:0] c_OP_AND   = 3'd2;
  localparam logic [2:0] c_OP_OR    = 3'd3;
  localparam logic [2:0] c_OP_SLT   = 3'd4;
  localparam logic [2:0] c_OP_NOR   = 3'd5;
  localparam logic [2:0] c_OP_MULTU = 3'd6;
  localparam logic [2:0] c_OP_DIVU  = 3'd7;

  logic [1:0]         r_state;
  logic [1:0]         w_nextState;
  logic [c_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_operand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_hiNext;
  logic [WIDTH-1:0]   w_loNext;
  logic [WIDTH-1:0]   w_aluRes;
  logic [WIDTH:0]     w_mulSum;
  logic               w_accept;
  logic               w_iterOp;
  logic               w_lastIter;

`ifdef ALU_DIVU_EN
  logic               r_isDiv;
  logic [WIDTH:0]     w_divRem;
  logic               w_divGe;
  logic [WIDTH-1:0]   w_divDiff;
`endif

  assign w_accept   = (r_state == c_IDLE) && start;
  assign w_lastIter = (r_count == c_LAST);
  assign Zero       = (ALUOut == '0);

`ifdef ALU_DIVU_EN
  assign w_iterOp = (ALUControl == c_OP_MULTU) || (ALUControl == c_OP_DIVU);
`else
  assign w_iterOp = (ALUControl == c_OP_MULTU);
`endif

  // Single-cycle result; code 7 falls to zero when the divider is absent.
  always_comb begin
    w_aluRes = '0;
    case (ALUControl)
      c_OP_ADD: w_aluRes = MuxAtoALU + MuxBtoALU;
      c_OP_SUB: w_aluRes = MuxAtoALU - MuxBtoALU;
      c_OP_AND: w_aluRes = MuxAtoALU & MuxBtoALU;
      c_OP_OR:  w_aluRes = MuxAtoALU | MuxBtoALU;
      c_OP_SLT: w_aluRes[0] = $signed(MuxAtoALU) < $signed(MuxBtoALU);
      c_OP_NOR: w_aluRes = ~(MuxAtoALU | MuxBtoALU);
      default:  w_aluRes = '0;
    endcase
  end

  // Multiply step: {hi,lo} holds partial product over the shifting multiplier.
  assign w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_operand} : '0);

`ifdef ALU_DIVU_EN
  // Divide step: hi is the remainder, lo shifts dividend out and quotient in.
  // A zero divisor always compares as fitting, giving all-ones and rem = A.
  assign w_divRem  = {r_hi, r_lo[WIDTH-1]};
  assign w_divGe   = (w_divRem >= {1'b0, r_operand});
  assign w_divDiff = w_divRem[WIDTH-1:0] - r_operand;
`endif

  always_comb begin
    w_hiNext = w_mulSum[WIDTH:1];
    w_loNext = {w_mulSum[0], r_lo[WIDTH-1:1]};
`ifdef ALU_DIVU_EN
    if (r_isDiv) begin
      w_hiNext = w_divGe ? w_divDiff : w_divRem[WIDTH-1:0];
      w_loNext = {r_lo[WIDTH-2:0], w_divGe};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  if (start) w_nextState = w_iterOp ? c_ITER : c_FIN;
      c_ITER:  if (w_lastIter) w_nextState = c_FIN;
      c_FIN:   w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == c_ITER);
    done = (r_state == c_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_operand <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      ALUOut    <= '0;
      HiOut     <= '0;
`ifdef ALU_DIVU_EN
      r_isDiv   <= 1'b0;
`endif
    end else if (w_accept) begin
      if (w_iterOp) begin
        r_count <= '0;
        r_hi    <= '0;
`ifdef ALU_DIVU_EN
        r_isDiv   <= (ALUControl == c_OP_DIVU);
        r_lo      <= (ALUControl == c_OP_DIVU) ? MuxAtoALU : MuxBtoALU;
        r_operand <= (ALUControl == c_OP_DIVU) ? MuxBtoALU : MuxAtoALU;
`else
        r_lo      <= MuxBtoALU;
        r_operand <= MuxAtoALU;
`endif
      end else begin
        ALUOut <= w_aluRes;
      end
    end else if (r_state == c_ITER) begin
      r_count <= r_count + 1'b1;
      r_hi    <= w_hiNext;
      r_lo    <= w_loNext;
      if (w_lastIter) begin
        ALUOut <= w_loNext;
        HiOut  <= w_hiNext;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of operands and results.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port MuxAtoALU, input, WIDTH, operand A from the ALU-source-A select stage.
REQ-005 SHALL have port MuxBtoALU, input, WIDTH, operand B from the ALU-source-B select stage.
REQ-006 SHALL have port ALUControl, input, 3, operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), 5 NOR, 6 MULTU, 7 DIVU.
REQ-007 SHALL have port start, input, 1, request to begin the operation on the current operands.
REQ-008 SHALL have port busy, output, 1, high while an iterative operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when ALUOut/HiOut hold a new result.
REQ-010 SHALL have port ALUOut, output, WIDTH, registered result (low product, quotient, or logic/arith result).
REQ-011 SHALL have port HiOut, output, WIDTH, registered high product or remainder.
REQ-012 SHALL have port Zero, output, 1, combinational (ALUOut == 0).

Function
REQ-013 SHALL implement FSM states IDLE, ITER, FIN; reset state IDLE.
REQ-014 SHALL sample start only in IDLE; start in ITER or FIN is ignored, with no effect on the current operation.
REQ-015 SHALL latch MuxAtoALU, MuxBtoALU and ALUControl at the edge where start is accepted; later operand changes do not affect the result.
REQ-016 For codes 0-5, SHALL write ALUOut at the accepting edge, leave HiOut unchanged, go to FIN, and pulse done in the following cycle (latency 1).
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-018 SLT SHALL produce 1 when A < B as signed two's complement, else 0.
REQ-019 MULTU SHALL be unsigned shift-add, one bit per cycle: ITER for exactly WIDTH cycles with busy high, then {HiOut, ALUOut} = A*B written on the transition to FIN, done high the cycle after.
REQ-020 Each FIN state SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-021 Back-to-back operation: start asserted during FIN SHALL be ignored; the earliest re-accept is the first IDLE cycle.
REQ-022 busy SHALL be high in ITER only; done SHALL be high in FIN only.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, ALUOut=0, HiOut=0, busy=0, done=0, and clear the iteration counter and partial product.
REQ-024 Reset asserted mid-ITER SHALL abort the operation with no done pulse; the first start after release begins a fresh operation.

Configuration
REQ-025 Macro ALU_DIVU_EN defined: DIVU (code 7) SHALL be unsigned restoring division over WIDTH ITER cycles with ALUOut=quotient and HiOut=remainder; divide-by-zero SHALL give ALUOut=all ones and HiOut=A, with the same WIDTH-cycle timing.
REQ-026 Macro ALU_DIVU_EN undefined: code 7 SHALL behave as a single-cycle op with ALUOut=0 and HiOut unchanged, and no divider logic SHALL be synthesized.

Verification
REQ-027 Reset, then start with ADD A=0xFFFFFFFF B=0x1 -> next cycle done=1, ALUOut=0, Zero=1, busy never high.
REQ-028 SLT A=0xFFFFFFFE B=0x1 -> ALUOut=1; SUB A=5 B=7 -> ALUOut=0xFFFFFFFE, Zero=0.
REQ-029 MULTU A=0xFFFFFFFF B=0x2 -> busy high for 32 cycles, then done one cycle with HiOut=0x1 and ALUOut=0xFFFFFFFE; start pulses mid-ITER ignored; operand changes after accept do not alter the result.
REQ-030 rst_n dropped at ITER cycle 10 of MULTU -> all outputs 0 immediately, no done pulse; a new ADD 3+4 after release gives ALUOut=7.
REQ-031 With ALU_DIVU_EN: DIVU 100/7 -> after 32 busy cycles ALUOut=14, HiOut=2; DIVU 9/0 -> ALUOut=0xFFFFFFFF, HiOut=9. Without ALU_DIVU_EN: DIVU 100/7 -> done after 1 cycle, ALUOut=0.
